muldiv_hilo_ctrl: RTL



---
 rtl/muldiv_pkg.sv | 67 ++++++
 rtl/muldiv_iter.sv | 69 ++++++
 rtl/parameters.sv | 16 +
 rtl/muldiv_hilo_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: FSM states, operation
// classes, the ALUOp decode and the divide-by-zero quotient constant.
`include "parameters.sv"

package muldiv_pkg;

   localparam int          CNT_W   = 5;
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   localparam logic [4:0] ALU_MULT  = `AluOp_Mult;
   localparam logic [4:0] ALU_MULTU = `AluOp_Multu;
   localparam logic [4:0] ALU_MADD  = `AluOp_Madd;
   localparam logic [4:0] ALU_MADDU = `AluOp_Maddu;
   localparam logic [4:0] ALU_MSUB  = `AluOp_Msub;
   localparam logic [4:0] ALU_MSUBU = `AluOp_Msubu;
   localparam logic [4:0] ALU_DIV   = `AluOp_Div;
   localparam logic [4:0] ALU_DIVU  = `AluOp_Divu;
   localparam logic [4:0] ALU_MTHI  = `AluOp_Mthi;
   localparam logic [4:0] ALU_MTLO  = `AluOp_Mtlo;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } state_e;

   typedef enum logic [2:0] {
      OPC_NONE,
      OPC_MUL,
      OPC_MAC_ADD,
      OPC_MAC_SUB,
      OPC_DIV,
      OPC_MTHI,
      OPC_MTLO
   } opc_e;

   typedef struct packed {
      opc_e opc;
      logic sgn;
   } dec_t;

   function automatic dec_t decode_op(input logic [4:0] op);
      dec_t d;
      d.opc = OPC_NONE;
      d.sgn = 1'b0;
      case (op)
         `AluOp_Mult:  begin d.opc = OPC_MUL;     d.sgn = 1'b1; end
         `AluOp_Multu: d.opc = OPC_MUL;
         `AluOp_Madd:  begin d.opc = OPC_MAC_ADD; d.sgn = 1'b1; end
         `AluOp_Maddu: d.opc = OPC_MAC_ADD;
         `AluOp_Msub:  begin d.opc = OPC_MAC_SUB; d.sgn = 1'b1; end
         `AluOp_Msubu: d.opc = OPC_MAC_SUB;
         `AluOp_Div:   begin d.opc = OPC_DIV;     d.sgn = 1'b1; end
         `AluOp_Divu:  d.opc = OPC_DIV;
         `AluOp_Mthi:  d.opc = OPC_MTHI;
         `AluOp_Mtlo:  d.opc = OPC_MTLO;
         default:      d.opc = OPC_NONE;
      endcase
      return d;
   endfunction

   function automatic logic is_engine_op(input opc_e opc);
      return (opc == OPC_MUL) || (opc == OPC_MAC_ADD) ||
             (opc == OPC_MAC_SUB) || (opc == OPC_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration engine: 64-bit product/remainder register with the
// shift-add (multiply) or restoring shift-subtract (divide) step.
// With MULDIV_EARLY_OUT_EN defined it also reports when no multiplier bits remain.
module muldiv_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        is_div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] acc_o
`ifdef MULDIV_EARLY_OUT_EN
   ,
   output logic        mpl_last_o
`endif
);

   logic [63:0] acc_q, acc_d;
   logic [63:0] mc_q, mc_d;
   logic [31:0] mpl_q, mpl_d;
   logic        is_div_q, is_div_d;
   logic [33:0] diff;

   // Partial remainder after the left shift is 33 bits wide.
   assign diff = {1'b0, acc_q[63:31]} - {2'b00, mc_q[31:0]};

   always_comb begin
      acc_d    = acc_q;
      mc_d     = mc_q;
      mpl_d    = mpl_q;
      is_div_d = is_div_q;
      if (load_i) begin
         is_div_d = is_div_i;
         acc_d    = is_div_i ? {32'h0, a_i} : 64'h0;
         mc_d     = is_div_i ? {32'h0, b_i} : {32'h0, a_i};
         mpl_d    = b_i;
      end else if (step_i) begin
         if (is_div_q) begin
            if (!diff[33]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            else           acc_d = {acc_q[62:0], 1'b0};
         end else begin
            if (mpl_q[0]) acc_d = acc_q + mc_q;
            mc_d  = {mc_q[62:0], 1'b0};
            mpl_d = {1'b0, mpl_q[31:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mc_q     <= '0;
         mpl_q    <= '0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mc_q     <= mc_d;
         mpl_q    <= mpl_d;
         is_div_q <= is_div_d;
      end
   end

   assign acc_o = acc_q;
`ifdef MULDIV_EARLY_OUT_EN
   assign mpl_last_o = ~|mpl_q[31:1];
`endif

endmodule

// File: rtl/parameters.sv
// ALUOp encodings shared with the ID-stage decoder.
`ifndef PARAMETERS_SV
`define PARAMETERS_SV

`define AluOp_Mult  5'h10
`define AluOp_Multu 5'h11
`define AluOp_Madd  5'h12
`define AluOp_Maddu 5'h13
`define AluOp_Msub  5'h14
`define AluOp_Msubu 5'h15
`define AluOp_Div   5'h16
`define AluOp_Divu  5'h17
`define AluOp_Mthi  5'h18
`define AluOp_Mtlo  5'h19

`endif

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, sign latch, FIX/commit stage, HI/LO registers.
// Defining MULDIV_EARLY_OUT_EN lets multiplies leave RUN once the multiplier is exhausted.
//
// state | meaning
// IDLE  | waiting; Mthi/Mtlo write HI/LO directly, engine ops load and go to RUN
// RUN   | one shift-add / shift-subtract iteration per cycle, flush aborts
// FIX   | sign correction and HI/LO commit, done pulses, flush ignored
module muldiv_hilo_ctrl
   import muldiv_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  alu_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        rd_req,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   opc_e             opc_q, opc_d;
   logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
   logic [31:0]      a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
   dec_t             dec;
   logic             eng_load, eng_step, early_out;
   logic [31:0]      a_mag, b_mag, quo, rem;
   logic [63:0]      acc, prod;

   assign dec      = decode_op(alu_op);
   assign a_mag    = (dec.sgn && op_a[31]) ? -op_a : op_a;
   assign b_mag    = (dec.sgn && op_b[31]) ? -op_b : op_b;
   assign eng_load = (state_q == ST_IDLE) && start && !flush && is_engine_op(dec.opc);
   assign eng_step = (state_q == ST_RUN);

   assign prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
   assign quo  = (a_neg_q ^ b_neg_q) ? -acc[31:0] : acc[31:0];
   assign rem  = a_neg_q ? -acc[63:32] : acc[63:32];

`ifdef MULDIV_EARLY_OUT_EN
   logic mpl_last;
   assign early_out = (opc_q != OPC_DIV) && mpl_last;
`else
   assign early_out = 1'b0;
`endif

   muldiv_iter u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (eng_load),
      .step_i     (eng_step),
      .is_div_i   (dec.opc == OPC_DIV),
      .a_i        (a_mag),
      .b_i        (b_mag),
      .acc_o      (acc)
`ifdef MULDIV_EARLY_OUT_EN
      ,
      .mpl_last_o (mpl_last)
`endif
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opc_d    = opc_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      b_zero_d = b_zero_q;
      a_raw_d  = a_raw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               case (dec.opc)
                  OPC_MTHI: hi_d = op_a;
                  OPC_MTLO: lo_d = op_a;
                  OPC_NONE: ;
                  default: begin
                     opc_d    = dec.opc;
                     a_neg_d  = dec.sgn & op_a[31];
                     b_neg_d  = dec.sgn & op_b[31];
                     b_zero_d = (op_b == 32'h0);
                     a_raw_d  = op_a;
                     cnt_d    = '0;
                     state_d  = ST_RUN;
                  end
               endcase
            end
         end
         ST_RUN: begin
            if (flush) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if ((opc_q == OPC_DIV && b_zero_q) || early_out ||
                         cnt_q == CNT_W'(ITERS - 1)) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FIX: begin
            case (opc_q)
               OPC_MAC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
               OPC_MAC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
               OPC_DIV: begin
                  if (b_zero_q) begin
                     lo_d = DIV0_LO;
                     hi_d = a_raw_q;
                  end else begin
                     lo_d = quo;
                     hi_d = rem;
                  end
               end
               default: {hi_d, lo_d} = prod;
            endcase
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         opc_q    <= OPC_NONE;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opc_q    <= opc_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         a_raw_q  <= a_raw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_FIX);
   assign stall = busy & (start | rd_req);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
